// File: rtl/hex_keypad_scanner_if.sv
// Keypad-side and value-side signals of the hex keypad scanner.
// The slave modport is the scanner; the master modport is the keypad and consumer side.
interface hex_keypad_scanner_if;
  logic [3:0]  row_in;
  logic        clear_in;
  logic [3:0]  col_out;
  logic [31:0] val_out;
  logic [3:0]  key_code;
  logic        key_valid;

  modport master (
    output row_in, clear_in,
    input  col_out, val_out, key_code, key_valid
  );

  modport slave (
    input  row_in, clear_in,
    output col_out, val_out, key_code, key_valid
  );
endinterface

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column drive, row synchronizer, whole-matrix debounce,
// and a 32-bit shift register holding the last eight accepted key codes.
module hex_keypad_scanner #(
  parameter int SCAN_DIV       = 200_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  hex_keypad_scanner_if.slave         kp
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DB_W  = (DEBOUNCE_SCANS < 1) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TARGET  = DB_W'(DEBOUNCE_SCANS);
  localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  logic [3:0]       r_sync1, r_sync2;
  logic [CNT_W-1:0] r_dwell;
  logic [3:0]       r_col;
  logic [1:0]       r_col_idx;
  logic [1:0]       r_acc_cnt;
  logic [3:0]       r_acc_code;
  state_t           r_state;
  logic [3:0]       r_cand;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_key_valid;
  logic [3:0]       r_key_code;
  logic [31:0]      r_val;

  logic             w_dwell_end, w_scan_done, w_one, w_none, w_accept;
  logic [2:0]       w_col_cnt, w_sum_raw;
  logic [1:0]       w_col_row, w_sum;
  logic [3:0]       w_scan_code, w_acc_code, w_cand_next;
  logic [DB_W-1:0]  w_cnt_inc, w_cnt_next;
  state_t           w_state_next;

  assign w_dwell_end = (r_dwell == DWELL_LAST);
  assign w_scan_done = w_dwell_end && (r_col_idx == 2'd3);

  // Low rows in the column currently sampled; row index is only meaningful when exactly one is low.
  always_comb begin
    w_col_cnt = 3'd0;
    w_col_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!r_sync2[r]) begin
        w_col_cnt = w_col_cnt + 3'd1;
        w_col_row = 2'(r);
      end
    end
  end

  // Key count saturates at 2, which is all that MULTI needs to distinguish.
  assign w_sum_raw   = {1'b0, r_acc_cnt} + w_col_cnt;
  assign w_sum       = (w_sum_raw >= 3'd2) ? 2'd2 : w_sum_raw[1:0];
  assign w_scan_code = (r_acc_cnt == 2'd0) ? {w_col_row, r_col_idx} : r_acc_code;
  assign w_one       = w_scan_done && (w_sum == 2'd1);
  assign w_none      = w_scan_done && (w_sum == 2'd0);
  assign w_cnt_inc   = r_db_cnt + DB_ONE;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync1    <= 4'b1111;
      r_sync2    <= 4'b1111;
      r_dwell    <= '0;
      r_col      <= 4'b1110;
      r_col_idx  <= 2'd0;
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
    end else begin
      r_sync1 <= kp.row_in;
      r_sync2 <= r_sync1;
      if (w_dwell_end) begin
        r_dwell   <= '0;
        r_col     <= {r_col[2:0], r_col[3]};
        r_col_idx <= r_col_idx + 2'd1;
        if (r_col_idx == 2'd3) begin
          r_acc_cnt  <= 2'd0;
          r_acc_code <= 4'd0;
        end else begin
          r_acc_cnt  <= w_sum;
          r_acc_code <= w_scan_code;
        end
      end else begin
        r_dwell <= r_dwell + CNT_W'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_cand   <= 4'd0;
      r_db_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cand   <= w_cand_next;
      r_db_cnt <= w_cnt_next;
    end
  end

  // FSM next state: only moves on a completed full-matrix scan.
  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_cnt_next   = r_db_cnt;
    if (w_scan_done) begin
      case (r_state)
        S_IDLE: if (w_one) begin
          w_cand_next  = w_scan_code;
          w_cnt_next   = DB_ONE;
          w_state_next = (DB_TARGET == DB_ONE) ? S_HELD : S_DEBOUNCE;
        end
        S_DEBOUNCE: if (w_one && (w_scan_code == r_cand)) begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == DB_TARGET) w_state_next = S_HELD;
        end else begin
          w_state_next = S_IDLE;
        end
        S_HELD: if (w_none) begin
          w_cnt_next   = DB_ONE;
          w_state_next = (DB_TARGET == DB_ONE) ? S_IDLE : S_RELEASE;
        end
        S_RELEASE: if (w_none) begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == DB_TARGET) w_state_next = S_IDLE;
        end else begin
          w_state_next = S_HELD;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // FSM outputs: accept strobe and the code being accepted.
  always_comb begin
    w_accept   = 1'b0;
    w_acc_code = r_cand;
    if (w_one) begin
      case (r_state)
        S_IDLE: begin
          w_acc_code = w_scan_code;
          w_accept   = (DB_TARGET == DB_ONE);
        end
        S_DEBOUNCE: w_accept = (w_scan_code == r_cand) && (w_cnt_inc == DB_TARGET);
        default:    w_accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
      r_val       <= 32'd0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= w_acc_code;
      if (kp.clear_in)
        r_val <= w_accept ? {28'd0, w_acc_code} : 32'd0;
      else if (w_accept)
        r_val <= {r_val[27:0], w_acc_code};
    end
  end

  assign kp.col_out   = r_col;
  assign kp.val_out   = r_val;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scans)
// and a behavioural keypad that pulls a row low while its pressed key's column is driven.
module tb_hex_keypad_scanner;

  localparam int SCAN = 16;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [15:0] pressed = 16'd0;
  logic [3:0]  row_model;
  int          vectors = 0;
  int          miscompares = 0;
  int          pulses = 0;
  int          cyc = 0;

  hex_keypad_scanner_if kif();

  hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .kp     (kif)
  );

  always #5 clk_in = ~clk_in;

  // Key code {r,c} doubles as the index into pressed.
  always_comb begin
    row_model = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.col_out[c]) row_model[r] = 1'b0;
  end
  assign kif.row_in = row_model;

  always @(negedge clk_in) if (kif.key_valid === 1'b1) pulses <= pulses + 1;
  always @(posedge clk_in) cyc <= rst_in ? 0 : cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
  endtask

  task automatic press_for(input int code, input int scans);
    pressed = 16'd0;
    pressed[code] = 1'b1;
    tick(scans * SCAN);
  endtask

  task automatic release_for(input int scans);
    pressed = 16'd0;
    tick(scans * SCAN);
  endtask

  task automatic align_scan();
    int guard;
    guard = 0;
    while ((cyc % SCAN) != 0 && guard < 2 * SCAN) begin
      tick(1);
      guard++;
    end
    vectors++;
    if ((cyc % SCAN) != 0) begin
      miscompares++;
      $display("FAIL align_scan: phase=%0d required=0", cyc % SCAN);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    int base;
    apply_reset();
    vectors++;
    if (kif.col_out !== 4'b1110 || kif.val_out !== 32'd0 || kif.key_valid !== 1'b0 || kif.key_code !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state: col=%b val=%h kv=%b code=%h required col=1110 val=0 kv=0 code=0",
               kif.col_out, kif.val_out, kif.key_valid, kif.key_code);
    end
    exp_col = 4'b1110;
    for (int i = 0; i < SCAN; i++) begin
      if (i != 0 && (i % 4) == 0) exp_col = {exp_col[2:0], exp_col[3]};
      vectors++;
      if (kif.col_out !== exp_col) begin
        miscompares++;
        $display("FAIL col_scan[%0d]: col=%b required=%b", i, kif.col_out, exp_col);
      end
      tick(1);
    end
    base = pulses;
    tick(10 * SCAN);
    vectors++;
    if (pulses != base) begin
      miscompares++;
      $display("FAIL idle_no_pulse: pulses=%0d required=0", pulses - base);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_key();
    int base;
    base = pulses;
    press_for(4'h6, 3);
    release_for(3);
    vectors++;
    if (pulses - base != 1 || kif.key_code !== 4'h6 || kif.val_out !== 32'h6) begin
      miscompares++;
      $display("FAIL key_6: pulses=%0d code=%h val=%h required 1/6/00000006", pulses - base, kif.key_code, kif.val_out);
    end
    press_for(4'hF, 3);
    release_for(3);
    vectors++;
    if (pulses - base != 2 || kif.key_code !== 4'hF || kif.val_out !== 32'h6F) begin
      miscompares++;
      $display("FAIL key_F: pulses=%0d code=%h val=%h required 2/f/0000006f", pulses - base, kif.key_code, kif.val_out);
    end
    $display("test_single_key done val=%h", kif.val_out);
  endtask

  task automatic test_bounce();
    int base;
    base = pulses;
    press_for(4'h1, 1);
    release_for(2);
    vectors++;
    if (pulses != base) begin
      miscompares++;
      $display("FAIL bounce_one_scan: pulses=%0d required=0", pulses - base);
    end
    pressed = 16'd0;
    pressed[4'h1] = 1'b1;
    pressed[4'h8] = 1'b1;
    tick(4 * SCAN);
    release_for(3);
    vectors++;
    if (pulses != base || kif.val_out !== 32'h6F) begin
      miscompares++;
      $display("FAIL multi_key: pulses=%0d val=%h required 0/0000006f", pulses - base, kif.val_out);
    end
    $display("test_bounce done");
  endtask

  task automatic test_hold();
    int base;
    base = pulses;
    press_for(4'h9, 20);
    vectors++;
    if (pulses - base != 1 || kif.key_code !== 4'h9) begin
      miscompares++;
      $display("FAIL long_hold: pulses=%0d code=%h required 1/9", pulses - base, kif.key_code);
    end
    release_for(1);
    press_for(4'h9, 4);
    release_for(3);
    vectors++;
    if (pulses - base != 1 || kif.val_out !== 32'h6F9) begin
      miscompares++;
      $display("FAIL release_glitch: pulses=%0d val=%h required 1/000006f9", pulses - base, kif.val_out);
    end
    $display("test_hold done val=%h", kif.val_out);
  endtask

  task automatic test_shift_clear();
    int base;
    apply_reset();
    base = pulses;
    for (int k = 1; k <= 9; k++) begin
      press_for(k, 3);
      release_for(3);
    end
    vectors++;
    if (pulses - base != 9 || kif.val_out !== 32'h23456789 || kif.key_code !== 4'h9) begin
      miscompares++;
      $display("FAIL nine_keys: pulses=%0d val=%h code=%h required 9/23456789/9", pulses - base, kif.val_out, kif.key_code);
    end
    align_scan();
    pressed = 16'd0;
    pressed[4'hA] = 1'b1;
    tick(2 * SCAN - 1);
    vectors++;
    if (kif.key_valid !== 1'b0 || kif.val_out !== 32'h23456789) begin
      miscompares++;
      $display("FAIL pre_accept_A: kv=%b val=%h required 0/23456789", kif.key_valid, kif.val_out);
    end
    kif.clear_in = 1'b1;
    tick(1);
    kif.clear_in = 1'b0;
    vectors++;
    if (kif.key_valid !== 1'b1 || kif.val_out !== 32'h0000000A || kif.key_code !== 4'hA) begin
      miscompares++;
      $display("FAIL clear_on_accept: kv=%b val=%h code=%h required 1/0000000a/a", kif.key_valid, kif.val_out, kif.key_code);
    end
    tick(1);
    vectors++;
    if (kif.key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_width: kv=%b required=0", kif.key_valid);
    end
    release_for(3);
    $display("test_shift_clear done val=%h", kif.val_out);
  endtask

  task automatic test_reset_mid_debounce();
    align_scan();
    pressed = 16'd0;
    pressed[4'h4] = 1'b1;
    tick(SCAN + 4);
    vectors++;
    if (kif.val_out !== 32'hA || kif.key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL in_debounce: val=%h kv=%b required 0000000a/0", kif.val_out, kif.key_valid);
    end
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    vectors++;
    if (kif.col_out !== 4'b1110 || kif.val_out !== 32'd0 || kif.key_valid !== 1'b0 || kif.key_code !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_reset: col=%b val=%h kv=%b code=%h required 1110/0/0/0",
               kif.col_out, kif.val_out, kif.key_valid, kif.key_code);
    end
    tick(2 * SCAN - 1);
    vectors++;
    if (kif.key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_accept: kv=%b required=0", kif.key_valid);
    end
    tick(1);
    vectors++;
    if (kif.key_valid !== 1'b1 || kif.val_out !== 32'h4 || kif.key_code !== 4'h4) begin
      miscompares++;
      $display("FAIL reaccept: kv=%b val=%h code=%h required 1/00000004/4", kif.key_valid, kif.val_out, kif.key_code);
    end
    release_for(3);
    $display("test_reset_mid_debounce done");
  endtask

  initial begin
    kif.clear_in = 1'b0;
    test_reset();
    test_single_key();
    test_bounce();
    test_hold();
    test_shift_clear();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
- Input-side counterpart of the 8-digit seven-segment display path.
- Scans a 4x4 matrix hex keypad by driving one active-low column at a time and sampling the active-low row lines.
- Debounces the result and shifts each accepted key code into a 32-bit value register.
- val_out is intended to feed the display controller's val_in directly; key_valid/key_code feed the core's I/O register block.

Parameters:
SCAN_DIV, 200_000, clock cycles each column stays driven; legal minimum 4.
DEBOUNCE_SCANS, 4, consecutive identical full-matrix scans required to accept a press or confirm a release; legal minimum 1.

Ports:
clk_in  input  1  system clock; every register updates on its rising edge.
rst_in  input  1  synchronous, active-high reset.
row_in  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk_in.
clear_in  input  1  synchronous clear of val_out.
col_out  output  4  keypad columns, active-low one-hot.
val_out  output  32  last eight accepted key codes; newest code in [3:0].
key_code  output  4  code of the most recently accepted key.
key_valid  output  1  one-cycle pulse when a key press is accepted.

Behaviour:
- Reset, on any clock edge with rst_in=1, including mid-scan or mid-debounce:
  - col_out=4'b1110, val_out=0, key_code=0, key_valid=0.
  - Dwell counter=0, column index=0, scan accumulator cleared, FSM=IDLE.
  - Row synchronizer flops set to 4'b1111.
- Row input: row_in passes through a 2-flop synchronizer before any use.
- Column scan:
  - Dwell counter counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0, and col_out rotates left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Column index c (0..3) tracks the low bit of col_out.
- Sampling:
  - Synchronized rows are sampled on the cycle where counter==SCAN_DIV-1, i.e. the last cycle of the dwell, so synchronizer latency is absorbed.
  - Each low row bit r in column c is one pressed key, with code={r[1:0],c[1:0]}.
- Scan result: evaluated at the column-3 sample, over all 16 positions.
  - NONE: 0 keys pressed.
  - ONE(k): exactly 1 key pressed, with code k.
  - MULTI: 2 or more keys pressed; treated as NONE for acceptance, but does not count as a release.
  - The accumulator clears for the next scan.
- FSM (advances only at scan-complete events):
  - IDLE:
    - ONE(k): cand<=k, cnt<=1, -> DEBOUNCE. If DEBOUNCE_SCANS==1, accept immediately and go to HELD.
    - Otherwise stay.
  - DEBOUNCE:
    - ONE(cand): cnt+1; when cnt reaches DEBOUNCE_SCANS, accept and -> HELD.
    - Any other result: -> IDLE.
  - HELD:
    - NONE: cnt<=1, -> RELEASE.
    - ONE or MULTI: stay. No auto-repeat.
  - RELEASE:
    - NONE: cnt+1; when cnt reaches DEBOUNCE_SCANS, -> IDLE.
    - ONE or MULTI: -> HELD.
- Accept:
  - Occurs on the clock edge ending the completing column-3 sample cycle.
  - Registered outputs update on that edge: key_valid=1 for exactly one cycle, key_code<=cand, val_out<={val_out[27:0],cand}.
  - The ninth key drops the oldest nibble.
- clear_in=1:
  - val_out<=0 on the next edge.
  - If it coincides with accept, val_out<={28'b0,cand}; key_valid and key_code behave normally.
  - No effect on scan or FSM.
- Timing and counter widths:
  - Minimum press-to-key_valid latency is DEBOUNCE_SCANS full scans (4*SCAN_DIV cycles each), plus up to one scan of alignment.
  - Dwell counter width is $clog2(SCAN_DIV) minimum; debounce counter width is $clog2(DEBOUNCE_SCANS+1) minimum. No overflow is permitted.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2, giving a 16-cycle scan; the keypad model pulls row r low while col_out[c]==0 for a pressed (r,c).
1. Reset -> col_out=1110, val_out=0, key_valid=0; with no key, col_out cycles 1110,1101,1011,0111 every 4 cycles, and key_valid never pulses over 10 scans.
2. Press (r=1,c=2) for 3 scans -> exactly one key_valid pulse, key_code=4'h6, val_out=32'h6; release 3 scans, press (3,3) -> val_out=32'h6F.
3. Bounce: press (0,1) for 1 scan only, then release -> no key_valid, FSM back in IDLE; hold (0,1) and (2,0) together for 4 scans -> no pulse.
4. Hold (2,1) for 20 scans -> exactly one pulse (code 9); a 1-scan release glitch mid-hold -> no second pulse.
5. Enter 9 keys 1..9 -> val_out=32'h23456789; clear_in asserted on the accept cycle of key A -> val_out=32'h0000000A.
6. Assert rst_in while in DEBOUNCE -> all outputs reset next edge; the key still held then accepts again after 2 fresh scans with val_out=its code.
